// File: rtl/strmatch_pkg.sv
// Shared types, width helpers and saturating arithmetic for the streaming string matcher.
package strmatch_pkg;

   typedef enum logic [1:0] {StIdle, StScan, StDrain, StReport} state_e;

   localparam int unsigned DEF_DWIDTH  = 8;
   localparam int unsigned DEF_PAT_NUM = 16;
   localparam int unsigned DEF_PAT_LEN = 8;
   localparam int unsigned DEF_CNT_W   = 16;

   // Never returns 0 so single-entry dimensions still get a 1-bit index.
   function automatic int unsigned clog2_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DEF_IDX_W = clog2_w(DEF_PAT_NUM);
   localparam int unsigned DEF_POS_W = clog2_w(DEF_PAT_LEN);
   localparam int unsigned DEF_LEN_W = clog2_w(DEF_PAT_LEN + 1);

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned width);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << width) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

endpackage

// File: rtl/pattern_cmp.sv
// Compares one pattern slot against the symbol window; window slot 0 holds the newest symbol.
module pattern_cmp
   import strmatch_pkg::*;
#(
   parameter int unsigned DWIDTH  = DEF_DWIDTH,
   parameter int unsigned PAT_LEN = DEF_PAT_LEN,
   parameter int unsigned LEN_W   = clog2_w(PAT_LEN + 1)
) (
   input  logic [PAT_LEN-1:0][DWIDTH-1:0] window,
   input  logic [LEN_W-1:0]               fill,
   input  logic [PAT_LEN-1:0][DWIDTH-1:0] pat,
   input  logic [LEN_W-1:0]               len,
   output logic                           hit
);

   // Pattern symbol k lines up with window slot len-1-k.
   always_comb begin
      hit = (len != '0) && (fill >= len);
      for (int k = 0; k < PAT_LEN; k++) begin
         for (int j = 0; j < PAT_LEN; j++) begin
            if ((j + k + 1 == int'(len)) && (window[j] != pat[k])) hit = 1'b0;
         end
      end
   end

endmodule

// File: rtl/string_match_stream.sv
// Streaming multi-pattern matcher: runtime pattern store, symbol window, per-string hit
// flags and saturating match count returned over a valid/ready result port.
module string_match_stream
   import strmatch_pkg::*;
#(
   parameter int unsigned DWIDTH  = DEF_DWIDTH,
   parameter int unsigned PAT_NUM = DEF_PAT_NUM,
   parameter int unsigned PAT_LEN = DEF_PAT_LEN,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              pat_we,
   input  logic [clog2_w(PAT_NUM)-1:0]       pat_idx,
   input  logic [clog2_w(PAT_LEN)-1:0]       pat_pos,
   input  logic [DWIDTH-1:0]                 pat_char,
   input  logic                              len_we,
   input  logic [clog2_w(PAT_LEN + 1)-1:0]   len_val,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DWIDTH-1:0]                 in_data,
   input  logic                              in_last,
   output logic                              res_valid,
   input  logic                              res_ready,
   output logic [PAT_NUM-1:0]                res_hits,
   output logic [CNT_W-1:0]                  res_count
);

   localparam int unsigned LEN_W = clog2_w(PAT_LEN + 1);

   state_e                                     state_q, state_d;
   logic [PAT_NUM-1:0][PAT_LEN-1:0][DWIDTH-1:0] pat_q, pat_d;
   logic [PAT_NUM-1:0][LEN_W-1:0]              len_q, len_d;
   logic [PAT_LEN-1:0][DWIDTH-1:0]             win_q, win_d;
   logic [LEN_W-1:0]                           fill_q, fill_d;
   logic                                       upd_q, upd_d;
   logic [PAT_NUM-1:0]                         hits_q, hits_d;
   logic [CNT_W-1:0]                           count_q, count_d;
   logic [PAT_NUM-1:0]                         hit_vec;
   logic [31:0]                                pop, sum;
   logic                                       accept, done, wr_ok;

   assign accept = in_valid && in_ready;
   assign done   = (state_q == StReport) && res_ready;
   assign wr_ok  = (state_q == StIdle) && (32'(pat_idx) < PAT_NUM);

   for (genvar i = 0; i < PAT_NUM; i++) begin : g_cmp
      pattern_cmp #(
         .DWIDTH  (DWIDTH),
         .PAT_LEN (PAT_LEN),
         .LEN_W   (LEN_W)
      ) u_cmp (
         .window (win_q),
         .fill   (fill_q),
         .pat    (pat_q[i]),
         .len    (len_q[i]),
         .hit    (hit_vec[i])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // upd_q marks that the window moved last edge, so its comparison is still to be counted.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = in_last ? StDrain : StScan;
         StScan:   if (accept && in_last) state_d = StDrain;
         StDrain:  if (!upd_q) state_d = StReport;
         StReport: if (res_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      res_valid = 1'b0;
      unique case (state_q)
         StIdle:   in_ready = !pat_we && !len_we;
         StScan:   in_ready = 1'b1;
         StReport: res_valid = 1'b1;
         default:  ;
      endcase
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < PAT_NUM; i++) pop = pop + 32'(hit_vec[i]);
      sum = sat_add(32'(count_q), pop, CNT_W);
   end

   always_comb begin
      pat_d   = pat_q;
      len_d   = len_q;
      win_d   = win_q;
      fill_d  = fill_q;
      hits_d  = hits_q;
      count_d = count_q;
      upd_d   = accept;
      if (pat_we && wr_ok && (32'(pat_pos) < PAT_LEN)) pat_d[pat_idx][pat_pos] = pat_char;
      if (len_we && wr_ok) begin
         len_d[pat_idx] = (32'(len_val) > PAT_LEN) ? LEN_W'(PAT_LEN) : len_val;
      end
      if (upd_q) begin
         hits_d  = hits_q | hit_vec;
         count_d = sum[CNT_W-1:0];
      end
      if (accept) begin
         for (int k = 1; k < PAT_LEN; k++) win_d[k] = win_q[k-1];
         win_d[0] = in_data;
         if (32'(fill_q) < PAT_LEN) fill_d = fill_q + 1'b1;
      end
      if (done) begin
         win_d   = '0;
         fill_d  = '0;
         hits_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q   <= '0;
         len_q   <= '0;
         win_q   <= '0;
         fill_q  <= '0;
         upd_q   <= 1'b0;
         hits_q  <= '0;
         count_q <= '0;
      end else begin
         pat_q   <= pat_d;
         len_q   <= len_d;
         win_q   <= win_d;
         fill_q  <= fill_d;
         upd_q   <= upd_d;
         hits_q  <= hits_d;
         count_q <= count_d;
      end
   end

   assign res_hits  = hits_q;
   assign res_count = count_q;

endmodule

// File: tb/tb_string_match_stream.sv
// Directed bench for string_match_stream with a reference string-search model feeding a
// result scoreboard; a second instance with a 2-bit counter covers saturation.
module tb_string_match_stream;
   import strmatch_pkg::*;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   pat_we, len_we, in_valid, in_last, res_ready;
   logic [DEF_IDX_W-1:0]   pat_idx;
   logic [DEF_POS_W-1:0]   pat_pos;
   logic [DEF_DWIDTH-1:0]  pat_char, in_data;
   logic [DEF_LEN_W-1:0]   len_val;
   logic                   in_ready, res_valid, in_ready2, res_valid2;
   logic [DEF_PAT_NUM-1:0] res_hits, res_hits2;
   logic [DEF_CNT_W-1:0]   res_count;
   logic [1:0]             res_count2;

   typedef struct packed {
      logic [15:0] hits;
      logic [15:0] count;
      logic [1:0]  count2;
   } exp_t;

   exp_t        sb[$];
   byte         m_pat[16][8];
   int          m_len[16];
   int          total = 0;
   int          passed = 0;

   string_match_stream u_dut (
      .clk(clk), .reset(reset), .pat_we(pat_we), .pat_idx(pat_idx), .pat_pos(pat_pos),
      .pat_char(pat_char), .len_we(len_we), .len_val(len_val), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .res_valid(res_valid),
      .res_ready(res_ready), .res_hits(res_hits), .res_count(res_count)
   );

   string_match_stream #(.CNT_W(2)) u_dut_sat (
      .clk(clk), .reset(reset), .pat_we(pat_we), .pat_idx(pat_idx), .pat_pos(pat_pos),
      .pat_char(pat_char), .len_we(len_we), .len_val(len_val), .in_valid(in_valid),
      .in_ready(in_ready2), .in_data(in_data), .in_last(in_last), .res_valid(res_valid2),
      .res_ready(res_ready), .res_hits(res_hits2), .res_count(res_count2)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 16; i++) begin
         m_len[i] = 0;
         for (int k = 0; k < 8; k++) m_pat[i][k] = 8'd0;
      end
   endtask

   // Plain substring search over the whole string, overlaps included.
   task automatic model(input string s, output logic [15:0] h, output int c);
      h = '0;
      c = 0;
      for (int i = 0; i < 16; i++) begin
         for (int e = m_len[i] - 1; m_len[i] > 0 && e < s.len(); e++) begin
            bit m = 1'b1;
            for (int k = 0; k < m_len[i]; k++) if (s[e - m_len[i] + 1 + k] != m_pat[i][k]) m = 1'b0;
            if (m) begin
               h[i] = 1'b1;
               c++;
            end
         end
      end
   endtask

   task automatic push_exp(input string s);
      exp_t        e;
      logic [15:0] h;
      int          c;
      model(s, h, c);
      e.hits   = h;
      e.count  = (c > 65535) ? 16'hffff : 16'(c);
      e.count2 = (c > 3) ? 2'd3 : 2'(c);
      sb.push_back(e);
   endtask

   task automatic write_pat(input int idx, input string s, input int len);
      for (int i = 0; i < s.len(); i++) begin
         pat_we   = 1'b1;
         pat_idx  = DEF_IDX_W'(idx);
         pat_pos  = DEF_POS_W'(i);
         pat_char = s[i];
         m_pat[idx][i] = s[i];
         step();
      end
      pat_we  = 1'b0;
      len_we  = 1'b1;
      pat_idx = DEF_IDX_W'(idx);
      len_val = DEF_LEN_W'(len);
      m_len[idx] = (len > 8) ? 8 : len;
      step();
      len_we = 1'b0;
   endtask

   task automatic send_sym(input byte c, input bit last);
      int n;
      in_valid = 1'b1;
      in_data  = c;
      in_last  = last;
      #1;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      chk("accept_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_str(input string s, input bit lat);
      push_exp(s);
      for (int i = 0; i < s.len(); i++) send_sym(s[i], i == s.len() - 1);
      if (lat) begin
         step();
         chk("latency_t1", res_valid, 0);
         step();
         chk("latency_t2", res_valid, 1);
      end
   endtask

   task automatic get_result(input string tag, input bit hold);
      exp_t e;
      int   n;
      n = 0;
      while (!res_valid && n < 50) begin
         step();
         n++;
      end
      chk({tag, "_valid"}, res_valid, 1);
      e = sb.pop_front();
      chk({tag, "_hits"}, res_hits, e.hits);
      chk({tag, "_count"}, res_count, e.count);
      chk({tag, "_count_sat"}, res_count2, e.count2);
      chk({tag, "_valid_sat"}, res_valid2, 1);
      if (hold) begin
         res_ready = 1'b0;
         repeat (5) begin
            step();
            chk({tag, "_hold_valid"}, res_valid, 1);
            chk({tag, "_hold_ready"}, in_ready, 0);
            chk({tag, "_hold_hits"}, res_hits, e.hits);
            chk({tag, "_hold_count"}, res_count, e.count);
         end
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk({tag, "_done_valid"}, res_valid, 0);
      chk({tag, "_done_hits"}, res_hits, 0);
   endtask

   initial begin
      logic [15:0] h;
      int          c;
      reset = 1'b1;
      {pat_we, len_we, in_valid, in_last, res_ready} = '0;
      pat_idx = '0; pat_pos = '0; pat_char = '0; in_data = '0; len_val = '0;
      clear_model();
      #12;
      reset = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_hits", res_hits, 0);
      chk("rst_res_count", res_count, 0);
      step();

      write_pat(0, "abc", 3);
      write_pat(1, "bc", 2);
      send_str("xabcab", 1);
      chk("basic_hits_const", res_hits, 16'h0003);
      chk("basic_count_const", res_count, 2);
      get_result("basic", 0);

      write_pat(0, "aa", 2);
      send_str("aaaa", 1);
      get_result("overlap", 1);

      write_pat(0, "abc", 3);
      send_str("ab", 0);
      get_result("split_a", 0);
      send_str("c", 1);
      get_result("split_b", 0);

      write_pat(2, "cd", 0);
      send_str("cd", 0);
      get_result("len0", 0);
      write_pat(2, "cd", 2);
      send_str("cd", 0);
      get_result("len2", 0);

      // Writes while scanning must not reach the store.
      push_exp("zz");
      send_sym("z", 1'b0);
      pat_we = 1'b1; pat_idx = 4'd3; pat_pos = 3'd0; pat_char = "z";
      #1;
      chk("scan_ready_with_we", in_ready, 1);
      step();
      pat_we = 1'b0; len_we = 1'b1; len_val = 4'd1;
      step();
      len_we = 1'b0;
      send_sym("z", 1'b1);
      get_result("scan_write", 0);
      send_str("z", 0);
      get_result("scan_write_after", 0);

      in_valid = 1'b1; in_data = "q"; in_last = 1'b1;
      pat_we = 1'b1; pat_idx = 4'd4; pat_pos = 3'd0; pat_char = "q";
      #1;
      chk("idle_we_blocks_ready", in_ready, 0);
      step();
      pat_we = 1'b0; len_we = 1'b1; len_val = 4'd1;
      #1;
      chk("idle_lenwe_blocks_ready", in_ready, 0);
      step();
      len_we = 1'b0;
      m_pat[4][0] = "q";
      m_len[4] = 1;
      push_exp("q");
      #1;
      chk("idle_ready_after_write", in_ready, 1);
      step();
      in_valid = 1'b0; in_last = 1'b0;
      get_result("write_priority", 0);

      write_pat(5, "abcdefgh", 15);
      send_str("abcdefgh", 1);
      get_result("clamp", 1);

      // Reset mid-string: partial result visible, then everything cleared at once.
      write_pat(0, "abc", 3);
      send_sym("a", 1'b0);
      send_sym("b", 1'b0);
      send_sym("c", 1'b0);
      step();
      model("abc", h, c);
      chk("mid_hits", res_hits, h);
      chk("mid_count", res_count, c);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_res_valid", res_valid, 0);
      chk("midrst_res_hits", res_hits, 0);
      chk("midrst_res_count", res_count, 0);
      step();
      reset = 1'b0;
      clear_model();
      send_str("abc", 0);
      get_result("store_cleared", 0);

      write_pat(0, "a", 1);
      send_str("aaaaa", 1);
      chk("sat_count_const", res_count2, 3);
      get_result("saturate", 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
